// File: rtl/l2_writeback_buffer.sv
// ---------------------------------------------------------------------------
// l2_writeback_buffer
//
// Write-back buffer between the L2 cache and physical memory. Dirty-line
// evictions from L2 are captured into a small FIFO of 256-bit lines and
// acknowledged immediately. The buffered lines are drained to pmem in the
// background. L2 line reads never return stale data: a read whose line is
// still buffered is either forwarded from the buffer or delayed until that
// line has been drained.
//
// Optional feature macro: L2_WB_BUF_FWD_EN
//   defined   : a read that hits a buffered line is served from the buffer.
//   undefined : a read that hits a buffered line drains entries until no
//               entry matches, then reads the line from pmem.
//   Write coalescing (one entry per line address) is present in both builds.
// ---------------------------------------------------------------------------
module l2_writeback_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         l2_pmem_read,
    input  logic                         l2_pmem_write,
    input  logic [31:0]                  l2_pmem_address,
    input  logic [255:0]                 l2_pmem_wdata,
    output logic [255:0]                 l2_pmem_rdata,
    output logic                         l2_pmem_resp,

    output logic                         pmem_read,
    output logic                         pmem_write,
    output logic [31:0]                  pmem_address,
    output logic [255:0]                 pmem_wdata,
    input  logic [255:0]                 pmem_rdata,
    input  logic                         pmem_resp,

    output logic [$clog2(DEPTH+1)-1:0]   buf_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_MEM = 2'd1,
        DRAIN  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Buffer storage: valid bit, line tag and line data per entry.
    logic [DEPTH-1:0] valid;
    logic [26:0]      tag_mem  [DEPTH];
    logic [255:0]     data_mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    // Line address latched for a pmem read, and the data returned to L2.
    logic [26:0]      rd_tag;
    logic [255:0]     rdata_q;

    // Request decode.
    logic [26:0]      req_tag;
    logic             hit;
    logic [PTR_W-1:0] hit_idx;
    logic             full;

    // Control strobes from the FSM to the datapath registers.
    logic             do_enq;
    logic             do_upd;
    logic             do_pop;
    logic             do_rd_lat;
    logic             do_cap;
    logic             do_fwd;

    // Byte-offset bits of the line address carry no meaning here.
    logic             unused_offset;
    assign unused_offset = ^l2_pmem_address[4:0];

    assign req_tag = l2_pmem_address[31:5];
    assign full    = (count == CNT_W'(DEPTH));

    // Associative lookup of the requested line; coalescing keeps hits unique.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (tag_mem[i] == req_tag)) begin
                hit     = 1'b1;
                hit_idx = PTR_W'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode, datapath strobes and pmem-side outputs.
    always_comb begin
        state_next   = state;
        do_enq       = 1'b0;
        do_upd       = 1'b0;
        do_pop       = 1'b0;
        do_rd_lat    = 1'b0;
        do_cap       = 1'b0;
        do_fwd       = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;

        case (state)
            IDLE: begin
                // Priority: read, then write, then background drain.
                if (l2_pmem_read) begin
                    if (hit) begin
`ifdef L2_WB_BUF_FWD_EN
                        do_fwd     = 1'b1;
                        state_next = RESP;
`else
                        // Push the matching line out before reading pmem.
                        state_next = DRAIN;
`endif
                    end else begin
                        do_rd_lat  = 1'b1;
                        state_next = RD_MEM;
                    end
                end else if (l2_pmem_write) begin
                    if (hit) begin
                        do_upd     = 1'b1;
                        state_next = RESP;
                    end else if (!full) begin
                        do_enq     = 1'b1;
                        state_next = RESP;
                    end else begin
                        // Make room; the write is retried from IDLE.
                        state_next = DRAIN;
                    end
                end else if (count != '0) begin
                    state_next = DRAIN;
                end
            end

            RD_MEM: begin
                pmem_read    = 1'b1;
                pmem_address = {rd_tag, 5'b0};
                if (pmem_resp) begin
                    do_cap     = 1'b1;
                    state_next = RESP;
                end
            end

            DRAIN: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_mem[head], 5'b0};
                pmem_wdata   = data_mem[head];
                if (pmem_resp) begin
                    do_pop     = 1'b1;
                    state_next = IDLE;
                end
            end

            RESP: begin
                // L2 drops its request on resp, so nothing is sampled here.
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Occupancy bookkeeping, read-address latch and returned-data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            rd_tag  <= '0;
            rdata_q <= '0;
        end else begin
            // Enqueue (IDLE) and pop (DRAIN) are never requested together.
            if (do_enq) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PTR_W'(1);
                count       <= count + CNT_W'(1);
            end
            if (do_pop) begin
                valid[head] <= 1'b0;
                head        <= head + PTR_W'(1);
                count       <= count - CNT_W'(1);
            end
            if (do_rd_lat) begin
                rd_tag <= req_tag;
            end
            if (do_cap) begin
                rdata_q <= pmem_rdata;
            end
`ifdef L2_WB_BUF_FWD_EN
            if (do_fwd) begin
                rdata_q <= data_mem[hit_idx];
            end
`endif
        end
    end

    // Line tag and data storage.
    always_ff @(posedge clk) begin
        // NOTE: the tag/data arrays are deliberately not reset; an entry is
        // only ever read while its valid bit (which is reset) is set.
        if (do_enq) begin
            tag_mem[tail]  <= req_tag;
            data_mem[tail] <= l2_pmem_wdata;
        end
        if (do_upd) begin
            data_mem[hit_idx] <= l2_pmem_wdata;
        end
    end

`ifndef L2_WB_BUF_FWD_EN
    // Without forwarding the forward strobe has no consumer.
    logic unused_fwd;
    assign unused_fwd = do_fwd;
`endif

    assign l2_pmem_resp  = (state == RESP);
    assign l2_pmem_rdata = rdata_q;
    assign buf_count     = count;

endmodule
